// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and stall controller for a five-stage pipeline. It decides, every
// cycle, which pipeline registers advance (enables) and which are cleared to a
// bubble (flush/"x" controls). The decision is combinational from the
// registered controller state and the current inputs, so it takes effect in
// the same cycle that the hazard is seen.
//
// Priority of the per-cycle decision (highest first):
//   1. TIMEOUT state : everything frozen until reset.
//   2. mem_busy      : everything frozen (data memory not ready).
//   3. branch_taken  : wrong-path IF/ID and ID/EX contents are flushed.
//   4. load_use      : PC and IF/ID hold, one bubble goes into EX.
//   5. otherwise     : everything advances.
//
// A run of consecutive mem_busy cycles is timed. When the run reaches
// TIMEOUT_LIMIT cycles the controller locks up in TIMEOUT and raises
// mem_timeout; only reset leaves that state.
//
// Ports
//   stg_clk            in   pipeline clock, all state on the rising edge
//   reset              in   asynchronous, active-high
//   id_rs1, id_rs2     in   [4:0] source registers of the instruction in ID
//   id_rs1_used,
//   id_rs2_used        in   the ID instruction actually reads rs1 / rs2
//   ex_rd              in   [4:0] destination register of the instruction in EX
//   ex_rd_memory       in   the EX instruction is a load
//   branch_taken       in   taken branch/jump resolved in EX this cycle
//   mem_busy           in   data memory stall request
//   clear_counters     in   synchronous clear of both event counters
//   pc_ena .. memwb_ena out  per-stage enables and flush controls
//   stall_cycles       out  [15:0] saturating count of cycles with PC held
//   flush_events       out  [15:0] saturating count of branch flushes
//   mem_timeout        out  memory lockup flag
//   state              out  [1:0] RUN=0, WAIT=1, TIMEOUT=2
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT_LIMIT = 255
) (
    input  logic        stg_clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  ex_rd,
    input  logic        ex_rd_memory,
    input  logic        branch_taken,
    input  logic        mem_busy,
    input  logic        clear_counters,
    output logic        pc_ena,
    output logic        ifid_ena,
    output logic        ifid_x,
    output logic        op_ena,
    output logic        op_x,
    output logic        exmem_ena,
    output logic        exmem_x,
    output logic        memwb_ena,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events,
    output logic        mem_timeout,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    // Limit widened by one bit so that wait_cnt + 1 can be compared without
    // wrapping when the limit is 255.
    localparam logic [8:0] LIMIT_W        = 9'(TIMEOUT_LIMIT);
    // With a limit of one, the very first busy cycle already exhausts the
    // budget, so WAIT is skipped entirely.
    localparam bit         DIRECT_TIMEOUT = (TIMEOUT_LIMIT == 1);
    localparam logic [15:0] CNT_MAX       = 16'hFFFF;

    state_t      state_reg;
    logic [7:0]  wait_cnt_reg;
    logic [15:0] stall_cnt_reg;
    logic [15:0] flush_cnt_reg;

    logic        load_use;
    logic        locked;
    logic        freeze;
    logic        do_flush;
    logic        do_bubble;
    logic        stall_inc;
    logic [8:0]  wait_cnt_inc;

    // -------------------------------------------------------------------------
    // Hazard detection and per-stage control (combinational, zero latency)
    // -------------------------------------------------------------------------
    always_comb begin
        // Register x0 is hard-wired to zero, so a load targeting it can never
        // create a dependency, whatever the load flag says.
        load_use = ex_rd_memory && (ex_rd != 5'd0) &&
                   ((id_rs1_used && (id_rs1 == ex_rd)) ||
                    (id_rs2_used && (id_rs2 == ex_rd)));

        locked    = (state_reg == ST_TIMEOUT);
        freeze    = locked || mem_busy;
        do_flush  = !freeze && branch_taken;
        // A taken branch discards the dependent instruction anyway, so the
        // load-use bubble is only needed when no flush happens.
        do_bubble = !freeze && !branch_taken && load_use;

        pc_ena    = 1'b1;
        ifid_ena  = 1'b1;
        ifid_x    = 1'b0;
        op_ena    = 1'b1;
        op_x      = 1'b0;
        exmem_ena = 1'b1;
        exmem_x   = 1'b0;
        memwb_ena = 1'b1;

        if (freeze) begin
            pc_ena    = 1'b0;
            ifid_ena  = 1'b0;
            op_ena    = 1'b0;
            exmem_ena = 1'b0;
            memwb_ena = 1'b0;
        end else if (do_flush) begin
            // The branch itself sits in EX and must still reach EX/MEM;
            // only the two younger wrong-path instructions are squashed.
            ifid_x = 1'b1;
            op_x   = 1'b1;
        end else if (do_bubble) begin
            // Hold fetch and decode, let the load move on, and feed a bubble
            // into EX so the dependent instruction re-reads next cycle.
            pc_ena   = 1'b0;
            ifid_ena = 1'b0;
            op_x     = 1'b1;
        end
    end

    // Lockup time is not counted as stall time: it is reported by mem_timeout.
    assign stall_inc    = !pc_ena && !locked;
    assign wait_cnt_inc = {1'b0, wait_cnt_reg} + 9'd1;

    // -------------------------------------------------------------------------
    // Memory-wait FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge stg_clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_RUN;
            wait_cnt_reg <= 8'd0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (mem_busy) begin
                        if (DIRECT_TIMEOUT) begin
                            state_reg <= ST_TIMEOUT;
                        end else begin
                            state_reg    <= ST_WAIT;
                            wait_cnt_reg <= 8'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_busy) begin
                        if (wait_cnt_inc == LIMIT_W) begin
                            state_reg <= ST_TIMEOUT;
                        end else begin
                            wait_cnt_reg <= wait_cnt_inc[7:0];
                        end
                    end else begin
                        state_reg    <= ST_RUN;
                        wait_cnt_reg <= 8'd0;
                    end
                end
                ST_TIMEOUT: begin
                    // Sticky until reset.
                    state_reg <= ST_TIMEOUT;
                end
                default: begin
                    state_reg    <= ST_RUN;
                    wait_cnt_reg <= 8'd0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Saturating event counters; a clear wins over a same-cycle increment
    // -------------------------------------------------------------------------
    always_ff @(posedge stg_clk or posedge reset) begin
        if (reset) begin
            stall_cnt_reg <= 16'd0;
            flush_cnt_reg <= 16'd0;
        end else if (clear_counters) begin
            stall_cnt_reg <= 16'd0;
            flush_cnt_reg <= 16'd0;
        end else begin
            if (stall_inc && (stall_cnt_reg != CNT_MAX)) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
            if (do_flush && (flush_cnt_reg != CNT_MAX)) begin
                flush_cnt_reg <= flush_cnt_reg + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_cnt_reg;
    assign flush_events = flush_cnt_reg;
    assign mem_timeout  = locked;
    assign state        = state_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Two controllers run side by side on the same stimulus: one with the default
// timeout limit of 255 and one with a limit of 4, so both the long-wait path
// and the lockup path are exercised. A reference model describes the
// controller in terms of "length of the current busy run" and "locked" rather
// than FSM states, and predicts outputs, state and counters every cycle.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic        stg_clk;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_rs1_used, id_rs2_used, ex_rd_memory;
    logic        branch_taken, mem_busy, clear_counters;

    logic        pc_ena_o[2], ifid_ena_o[2], ifid_x_o[2], op_ena_o[2];
    logic        op_x_o[2], exmem_ena_o[2], exmem_x_o[2], memwb_ena_o[2];
    logic [15:0] stall_o[2], flush_o[2];
    logic        timeout_o[2];
    logic [1:0]  state_o[2];

    pipe_hazard_ctrl #(.TIMEOUT_LIMIT(255)) u_dut255 (
        .stg_clk(stg_clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_rd_memory(ex_rd_memory),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .clear_counters(clear_counters),
        .pc_ena(pc_ena_o[0]), .ifid_ena(ifid_ena_o[0]), .ifid_x(ifid_x_o[0]),
        .op_ena(op_ena_o[0]), .op_x(op_x_o[0]), .exmem_ena(exmem_ena_o[0]),
        .exmem_x(exmem_x_o[0]), .memwb_ena(memwb_ena_o[0]),
        .stall_cycles(stall_o[0]), .flush_events(flush_o[0]),
        .mem_timeout(timeout_o[0]), .state(state_o[0])
    );

    pipe_hazard_ctrl #(.TIMEOUT_LIMIT(4)) u_dut4 (
        .stg_clk(stg_clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_rd_memory(ex_rd_memory),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .clear_counters(clear_counters),
        .pc_ena(pc_ena_o[1]), .ifid_ena(ifid_ena_o[1]), .ifid_x(ifid_x_o[1]),
        .op_ena(op_ena_o[1]), .op_x(op_x_o[1]), .exmem_ena(exmem_ena_o[1]),
        .exmem_x(exmem_x_o[1]), .memwb_ena(memwb_ena_o[1]),
        .stall_cycles(stall_o[1]), .flush_events(flush_o[1]),
        .mem_timeout(timeout_o[1]), .state(state_o[1])
    );

    initial stg_clk = 1'b0;
    always #5 stg_clk = ~stg_clk;

    int errors = 0;
    int checks = 0;

    // Reference model state, one entry per instance.
    int unsigned lim[2]      = '{255, 4};
    int unsigned busy_run[2];
    bit          locked[2];
    int unsigned stall_m[2];
    int unsigned flush_m[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected stage controls, packed as
    // {pc_ena, ifid_ena, ifid_x, op_ena, op_x, exmem_ena, exmem_x, memwb_ena}.
    function automatic logic [7:0] exp_outs(input bit lk);
        bit lu;
        lu = ex_rd_memory && (ex_rd != 5'd0) &&
             ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
        if (lk || mem_busy) return 8'b0000_0000;
        if (branch_taken)   return 8'b1111_1101;
        if (lu)             return 8'b0001_1101;
        return 8'b1101_0101;
    endfunction

    function automatic logic [7:0] obs_outs(input int i);
        return {pc_ena_o[i], ifid_ena_o[i], ifid_x_o[i], op_ena_o[i],
                op_x_o[i], exmem_ena_o[i], exmem_x_o[i], memwb_ena_o[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            busy_run[i] = 0;
            locked[i]   = 0;
            stall_m[i]  = 0;
            flush_m[i]  = 0;
        end
    endtask

    task automatic model_edge();
        logic [7:0] e;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                busy_run[i] = 0; locked[i] = 0; stall_m[i] = 0; flush_m[i] = 0;
            end else begin
                e = exp_outs(locked[i]);
                if (clear_counters) begin
                    stall_m[i] = 0;
                    flush_m[i] = 0;
                end else if (!locked[i]) begin
                    if (!e[7] && stall_m[i] < 65535) stall_m[i]++;
                    if (!mem_busy && branch_taken && flush_m[i] < 65535) flush_m[i]++;
                end
                if (!locked[i]) begin
                    if (mem_busy) begin
                        busy_run[i]++;
                        if (busy_run[i] >= lim[i]) locked[i] = 1;
                    end else begin
                        busy_run[i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_outs();
        check("outs_lim255", 32'(obs_outs(0)), 32'(exp_outs(locked[0])));
        check("outs_lim4",   32'(obs_outs(1)), 32'(exp_outs(locked[1])));
    endtask

    task automatic check_regs();
        for (int i = 0; i < 2; i++) begin
            check(i == 0 ? "state_lim255" : "state_lim4", 32'(state_o[i]),
                  locked[i] ? 32'd2 : (busy_run[i] > 0 ? 32'd1 : 32'd0));
            check(i == 0 ? "timeout_lim255" : "timeout_lim4", 32'(timeout_o[i]), 32'(locked[i]));
            check(i == 0 ? "stall_lim255" : "stall_lim4", 32'(stall_o[i]), stall_m[i]);
            check(i == 0 ? "flush_lim255" : "flush_lim4", 32'(flush_o[i]), flush_m[i]);
        end
    endtask

    // One clock: combinational outputs checked mid-cycle, registers after the edge.
    task automatic tick(input bit chk);
        @(negedge stg_clk);
        if (chk) check_outs();
        @(posedge stg_clk);
        model_edge();
        #1;
        if (chk) check_regs();
    endtask

    task automatic set_idle();
        id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        ex_rd = 0; ex_rd_memory = 0; branch_taken = 0; mem_busy = 0;
        clear_counters = 0;
    endtask

    task automatic set_load_use();
        set_idle();
        ex_rd_memory = 1; ex_rd = 5'd5; id_rs2_used = 1; id_rs2 = 5'd5;
    endtask

    // Reset takes effect without a clock edge; checked before the next edge.
    task automatic apply_reset();
        reset = 1'b1;
        set_idle();
        #2;
        model_reset();
        check_regs();
        tick(1);
        reset = 1'b0;
    endtask

    task automatic clear_tick();
        set_idle();
        clear_counters = 1;
        tick(1);
        clear_counters = 0;
    endtask

    initial begin
        reset = 1'b1;
        set_idle();
        model_reset();

        $display("step reset: hold reset with idle inputs");
        apply_reset();
        tick(1);

        $display("step load_use: rs2 depends on load into x5");
        clear_tick();
        set_load_use();
        tick(1);
        set_idle();
        tick(1);
        check("load_use_stall_count", 32'(stall_o[0]), 32'd1);

        $display("step branch_over_load_use: flush wins over bubble");
        clear_tick();
        set_load_use();
        branch_taken = 1;
        tick(1);
        set_idle();
        tick(1);
        check("branch_flush_count", 32'(flush_o[0]), 32'd1);
        check("branch_stall_count", 32'(stall_o[0]), 32'd0);

        $display("step mem_busy_3: three busy cycles then resume");
        clear_tick();
        mem_busy = 1;
        repeat (3) tick(1);
        check("busy3_state_wait", 32'(state_o[0]), 32'd1);
        mem_busy = 0;
        tick(1);
        check("busy3_state_run", 32'(state_o[0]), 32'd0);
        check("busy3_stall_count", 32'(stall_o[0]), 32'd3);

        $display("step mem_busy_4: limit-4 instance locks up");
        mem_busy = 1;
        repeat (4) tick(1);
        check("lockup_state", 32'(state_o[1]), 32'd2);
        check("lockup_flag", 32'(timeout_o[1]), 32'd1);
        set_load_use();
        branch_taken = 1;
        repeat (3) tick(1);
        check("lockup_frozen_outs", 32'(obs_outs(1)), 32'd0);
        apply_reset();
        check("post_reset_state", 32'(state_o[1]), 32'd0);

        $display("step reset_mid_wait: reset while mem_busy still high");
        mem_busy = 1;
        repeat (2) tick(1);
        reset = 1'b1;
        #2;
        model_reset();
        check("async_reset_wait_state", 32'(state_o[0]), 32'd0);
        check_regs();
        tick(1);
        reset = 1'b0;
        mem_busy = 0;
        tick(1);

        $display("step x0_load: load to x0 never stalls");
        set_idle();
        ex_rd_memory = 1; ex_rd = 5'd0; id_rs1_used = 1; id_rs1 = 5'd0;
        tick(1);
        check("x0_no_bubble_pc_ena", 32'(pc_ena_o[0]), 32'd1);

        $display("step random: 2000 random cycles");
        for (int n = 0; n < 2000; n++) begin
            if (n % 250 == 249) begin
                apply_reset();
            end else begin
                id_rs1         = 5'($urandom_range(0, 3));
                id_rs2         = 5'($urandom_range(0, 3));
                ex_rd          = 5'($urandom_range(0, 3));
                id_rs1_used    = 1'($urandom_range(0, 1));
                id_rs2_used    = 1'($urandom_range(0, 1));
                ex_rd_memory   = 1'($urandom_range(0, 1));
                branch_taken   = ($urandom_range(0, 4) == 0);
                mem_busy       = ($urandom_range(0, 7) == 0);
                clear_counters = ($urandom_range(0, 31) == 0);
                tick(1);
            end
        end

        $display("step saturate: 65540 load-use stalls");
        apply_reset();
        set_load_use();
        for (int n = 0; n < 65540; n++) tick(0);
        tick(1);
        check("stall_saturated", 32'(stall_o[0]), 32'hFFFF);
        clear_tick();
        check("stall_cleared", 32'(stall_o[0]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT_LIMIT, 255, consecutive mem_busy cycles before lockup (legal 1..255).
REQ-002 SHALL have port: stg_clk  in  1  pipeline clock, all state on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high.
REQ-004 SHALL have ports: id_rs1, id_rs2  in  5 each  source registers of the instruction in decode.
REQ-005 SHALL have ports: id_rs1_used, id_rs2_used  in  1 each  decode instruction reads rs1/rs2.
REQ-006 SHALL have ports: ex_rd  in  5, ex_rd_memory  in  1  destination and load flag from the operand latch outputs (instruction in EX).
REQ-007 SHALL have ports: branch_taken  in  1  taken branch/jump resolved in EX this cycle; mem_busy  in  1  data memory stall request; clear_counters  in  1  synchronous counter clear.
REQ-008 SHALL have ports: pc_ena, ifid_ena, ifid_x, op_ena, op_x, exmem_ena, exmem_x, memwb_ena  out  1 each  per-stage enable/flush (op_* drive the operand latch stg_ena/stg_x).
REQ-009 SHALL have ports: stall_cycles  out  16, flush_events  out  16  saturating counters; mem_timeout  out  1  lockup flag; state  out  2  FSM state (RUN=0, WAIT=1, TIMEOUT=2).

Function
REQ-010 SHALL implement a registered FSM RUN/WAIT/TIMEOUT plus 8-bit wait_cnt; stage outputs are combinational from state and current inputs (zero-cycle latency).
REQ-011 SHALL define load_use = ex_rd_memory & (ex_rd!=0) & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
REQ-012 SHALL, when mem_busy=1 in RUN or WAIT, freeze: all *_ena=0, all *_x=0 (highest priority).
REQ-013 SHALL, in RUN/WAIT with mem_busy=0 and branch_taken=1, flush: all *_ena=1, ifid_x=1, op_x=1, exmem_x=0 (branch in EX proceeds; wrong-path IF/ID and ID/EX cleared).
REQ-014 SHALL, with mem_busy=0, branch_taken=0, load_use=1, insert one bubble: pc_ena=0, ifid_ena=0, op_x=1, op_ena=1, exmem_ena=1, memwb_ena=1.
REQ-015 SHALL otherwise output all *_ena=1, all *_x=0.
REQ-016 SHALL transition RUN->WAIT on mem_busy=1 with wait_cnt<=1; if TIMEOUT_LIMIT==1 go directly RUN->TIMEOUT.
REQ-017 SHALL in WAIT with mem_busy=1: if wait_cnt+1==TIMEOUT_LIMIT go TIMEOUT, else wait_cnt<=wait_cnt+1.
REQ-018 SHALL in WAIT with mem_busy=0 return to RUN, applying REQ-013..015 in that same cycle; wait_cnt<=0.
REQ-019 SHALL in TIMEOUT hold all *_ena=0, *_x=0, mem_timeout=1, ignoring all inputs, until reset.
REQ-020 SHALL increment stall_cycles each edge where pc_ena=0 and state!=TIMEOUT, saturating at 0xFFFF.
REQ-021 SHALL increment flush_events each edge where REQ-013 applies, saturating at 0xFFFF.
REQ-022 SHALL give clear_counters=1 priority over increment (counters become 0 at that edge).
REQ-023 SHALL treat ex_rd==0 as never hazardous, independent of ex_rd_memory.

Reset
REQ-024 SHALL on reset=1 asynchronously set state=RUN, wait_cnt=0, stall_cycles=0, flush_events=0, mem_timeout=0.
REQ-025 SHALL present RUN default outputs (REQ-015) while reset is held, given idle inputs.
REQ-026 SHALL abort WAIT/TIMEOUT immediately on reset mid-operation, without requiring mem_busy deassertion.

Verification
REQ-027 SHALL cover: ex_rd_memory=1, ex_rd=5, id_rs2_used=1, id_rs2=5 for 1 cycle -> pc_ena=0, ifid_ena=0, op_x=1; stall_cycles=1.
REQ-028 SHALL cover: same as REQ-027 plus branch_taken=1 -> ifid_x=1, op_x=1, pc_ena=1; flush_events=1, stall_cycles=0.
REQ-029 SHALL cover: mem_busy=1 for 3 cycles, TIMEOUT_LIMIT=255 -> all ena=0 for 3 cycles, state=WAIT, then RUN; stall_cycles=3.
REQ-030 SHALL cover: TIMEOUT_LIMIT=4, mem_busy held 4 cycles -> state=TIMEOUT, mem_timeout=1, outputs frozen after mem_busy drops; reset -> RUN, counters 0.
REQ-031 SHALL cover: ex_rd=0 load with id_rs1=0 used -> no bubble; and 65540 load-use stalls -> stall_cycles=0xFFFF, clear_counters -> 0.
